// File: rtl/layer2_maxpool_stream.sv
// 2x2 / stride-2 max-pooling stage between the layer-2 convolution and layer-3 input.
// Raster-order pixel stream in, one pooled pixel out per completed window.
module layer2_maxpool_stream #(
  parameter int BITS       = 16,
  parameter int BITS_SHIFT = 4,
  parameter int CH         = 32,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         valid_in,
  input  logic [(CH<<BITS_SHIFT)-1:0]  data_in,
  output logic                         valid_out,
  output logic [(CH<<BITS_SHIFT)-1:0]  data_out,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int BUS_W  = CH << BITS_SHIFT;
  localparam int LANE_W = 1 << BITS_SHIFT;
  localparam int CD_W   = CH * BITS;
  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_D   = IMG_W / 2;
  localparam int LBW    = (LB_D > 1) ? $clog2(LB_D) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Internal storage keeps only the BITS data bits of each lane; padding never enters.
  function automatic logic [CD_W-1:0] unpack_lanes(input logic [BUS_W-1:0] bus);
    logic [CD_W-1:0] res;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      res[c*BITS +: BITS] = bus[c*LANE_W +: BITS];
    end
    return res;
  endfunction

  function automatic logic [BUS_W-1:0] pack_lanes(input logic [CD_W-1:0] lanes);
    logic [BUS_W-1:0] res;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      res[c*LANE_W +: BITS] = lanes[c*BITS +: BITS];
    end
    return res;
  endfunction

  function automatic logic [CD_W-1:0] lane_max(input logic [CD_W-1:0] a,
                                               input logic [CD_W-1:0] b);
    logic [CD_W-1:0] res;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      if (a[c*BITS +: BITS] > b[c*BITS +: BITS]) begin
        res[c*BITS +: BITS] = a[c*BITS +: BITS];
      end else begin
        res[c*BITS +: BITS] = b[c*BITS +: BITS];
      end
    end
    return res;
  endfunction

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic [CD_W-1:0]  hold_q, hold_d;
  logic             valid_out_q, valid_out_d;
  logic [BUS_W-1:0] data_out_q, data_out_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [CD_W-1:0]  linebuf_q [LB_D];
  logic             lb_we;
  logic [LBW-1:0]   lb_addr;
  logic [CD_W-1:0]  lb_wdata;
  logic [CD_W-1:0]  lb_rdata;
  logic [CD_W-1:0]  in_lanes;
  logic [CD_W-1:0]  pair_max;
  logic [1:0]       phase;
  logic             last_beat;

  // Next-state: counters, window phase decode, hold/line-buffer writes and output capture.
  always_comb begin
    if (start) begin
      col_eff = '0;
      row_eff = '0;
    end else begin
      col_eff = col_q;
      row_eff = row_q;
    end

    phase     = {row_eff[0], col_eff[0]};
    last_beat = (col_eff == COL_LAST) && (row_eff == ROW_LAST);
    in_lanes  = unpack_lanes(data_in);
    lb_addr   = LBW'(col_eff >> 1);
    lb_rdata  = linebuf_q[lb_addr];
    pair_max  = lane_max(hold_q, in_lanes);
    lb_wdata  = pair_max;
    lb_we     = 1'b0;

    col_d        = col_eff;
    row_d        = row_eff;
    hold_d       = hold_q;
    valid_out_d  = 1'b0;
    data_out_d   = data_out_q;
    frame_done_d = 1'b0;

    if (start && !valid_in) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    if (valid_in) begin
      busy_d = 1'b1;

      if (col_eff == COL_LAST) begin
        col_d = '0;
        if (row_eff == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_eff + RW'(1);
        end
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end

      case (phase)
        2'b00, 2'b10: begin
          hold_d = in_lanes;
        end
        2'b01: begin
          lb_we = 1'b1;
        end
        2'b11: begin
          // Bottom-right beat closes the window; the result is registered on this edge.
          valid_out_d = 1'b1;
          data_out_d  = pack_lanes(lane_max(pair_max, lb_rdata));
          if (last_beat) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            frame_done_d = 1'b0;
          end
        end
        default: begin
          hold_d = hold_q;
        end
      endcase
    end else begin
      hold_d = hold_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Horizontal partial maxima; entries are always rewritten on an even row before use.
  always_ff @(posedge clk_in) begin
    if (lb_we) begin
      linebuf_q[lb_addr] <= lb_wdata;
    end
  end

  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_layer2_maxpool_stream.sv
// Scoreboard bench for layer2_maxpool_stream at IMG 4x4, CH=2, 32-bit lane stride
// so that lane padding bits exist and can be exercised.
module tb_layer2_maxpool_stream;

  localparam int BITS       = 16;
  localparam int BITS_SHIFT = 5;
  localparam int CH         = 2;
  localparam int IMG_W      = 4;
  localparam int IMG_H      = 4;
  localparam int LANE_W     = 1 << BITS_SHIFT;
  localparam int BUS_W      = CH * LANE_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             valid_in;
  logic [BUS_W-1:0] data_in;
  logic             valid_out;
  logic [BUS_W-1:0] data_out;
  logic             frame_done;
  logic             busy;

  typedef struct {
    logic [BUS_W-1:0] data;
    logic             fd;
    int               cyc;
  } ev_t;

  ev_t              exp_q[$];
  ev_t              obs_q[$];
  logic [BUS_W-1:0] frame [IMG_H][IMG_W];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  layer2_maxpool_stream #(
    .BITS(BITS), .BITS_SHIFT(BITS_SHIFT), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk_in(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every output event with the cycle it appeared in.
  always @(negedge clk) begin
    if (valid_out || frame_done) begin
      ev_t o;
      o.data = data_out;
      o.fd   = frame_done;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  // Reference pooling: per-lane unsigned max of the low BITS bits, padding zero.
  function automatic logic [BUS_W-1:0] win_max(input int wr, input int wc);
    logic [BUS_W-1:0] res;
    logic [15:0] m;
    logic [BUS_W-1:0] px;
    res = '0;
    for (int l = 0; l < CH; l++) begin
      m = 16'd0;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          px = frame[2*wr+i][2*wc+j];
          if (px[l*LANE_W +: BITS] > m) m = px[l*LANE_W +: BITS];
        end
      end
      res[l*LANE_W +: BITS] = m;
    end
    return res;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame[r][c] = {$urandom(), $urandom()};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      start    = 1'b0;
      data_in  = {$urandom(), $urandom()};
    end
  endtask

  // Drives nbeats raster-order beats of frame[]; pushes the expected result of every
  // window whose bottom-right beat is driven. Leaves the last beat on the bus.
  task automatic send_frame(input int nbeats, input bit gapped, input bit start_first);
    int r;
    int c;
    ev_t e;
    for (int k = 0; k < nbeats; k++) begin
      r = (k / IMG_W) % IMG_H;
      c = k % IMG_W;
      @(negedge clk);
      start    = (k == 0) && start_first;
      valid_in = 1'b1;
      data_in  = frame[r][c];
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.data = win_max(r / 2, c / 2);
        e.fd   = (r == IMG_H - 1) && (c == IMG_W - 1);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      if (gapped && (k != nbeats - 1)) idle(1);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b, expected 0", valid_out); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h, expected 0", data_out); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_ramp();
    logic [15:0] l0_ref [4] = '{16'd17, 16'd19, 16'd49, 16'd51};
    logic [15:0] l1_ref [4] = '{16'd255, 16'd253, 16'd223, 16'd221};
    logic [15:0] l0;
    ev_t o, e;
    int k;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        l0 = 16'(16 * r + c);
        frame[r][c] = {16'h0000, 16'd255 - l0, 16'h0000, l0};
      end
    send_frame(16, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_checks++; if (frame_done !== 1'b1 || valid_out !== 1'b1) begin n_fail++; $display("FAIL ramp_done: got fd=%b vo=%b, expected 1 1", frame_done, valid_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy: got %b, expected 0", busy); end
    idle(4);
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ramp_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL ramp_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
      if (k < 4) begin
        n_checks++;
        if (o.data[15:0] !== l0_ref[k] || o.data[47:32] !== l1_ref[k]) begin
          n_fail++; $display("FAIL ramp_const: got lane0=%0d lane1=%0d, expected %0d %0d", o.data[15:0], o.data[47:32], l0_ref[k], l1_ref[k]);
        end
      end
      k++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    ev_t o, e;
    fill_random();
    send_frame(5, 1'b0, 1'b0);
    idle(1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (valid_out !== 1'b0 || data_out !== '0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got vo=%b do=%h fd=%b busy=%b, expected all 0", valid_out, data_out, frame_done, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    send_frame(16, 1'b0, 1'b0);
    idle(4);
    n_checks++; if (obs_q.size() !== 4 || exp_q.size() !== 4) begin n_fail++; $display("FAIL midrst_count: got %0d events, expected 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL midrst_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gapped();
    ev_t o, e;
    logic [15:0] l0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        l0 = 16'(16 * r + c);
        frame[r][c] = {16'h0000, 16'd255 - l0, 16'h0000, l0};
      end
    send_frame(16, 1'b1, 1'b0);
    idle(4);
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL gap_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL gap_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_unsigned_max();
    ev_t o, e;
    logic [15:0] w0 [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
    bit first;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame[r][c] = {16'hFFFF, 16'($urandom()), 16'hFFFF, 16'($urandom())};
    frame[0][0][15:0] = w0[0];
    frame[0][1][15:0] = w0[1];
    frame[1][0][15:0] = w0[2];
    frame[1][1][15:0] = w0[3];
    send_frame(16, 1'b0, 1'b0);
    idle(4);
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL umax_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    first = 1'b1;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL umax_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
      if (first) begin
        n_checks++;
        if (o.data[15:0] !== 16'h8000 || o.data[31:16] !== 16'h0000 || o.data[63:48] !== 16'h0000) begin
          n_fail++; $display("FAIL umax_lane0: got %h, expected lane0 8000 with zero padding", o.data);
        end
      end
      first = 1'b0;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_restart();
    ev_t o, e;
    // The sixth beat already closes window (0,0) of the partial frame; nothing after it may appear.
    fill_random();
    send_frame(6, 1'b0, 1'b0);
    idle(2);
    fill_random();
    send_frame(16, 1'b0, 1'b1);
    idle(4);
    // Standalone start with no beat must drop busy and rewind the counters.
    fill_random();
    send_frame(3, 1'b0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy: got %b, expected 0", busy); end
    fill_random();
    send_frame(16, 1'b0, 1'b0);
    idle(4);
    n_checks++; if (obs_q.size() !== 9 || exp_q.size() !== 9) begin n_fail++; $display("FAIL restart_count: got %0d events, expected 9", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL restart_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    int n_fd;
    fill_random();
    send_frame(16, 1'b0, 1'b0);
    fill_random();
    send_frame(16, 1'b0, 1'b0);
    idle(4);
    n_checks++; if (obs_q.size() !== 8 || exp_q.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d events, expected 8", obs_q.size()); end
    n_fd = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.fd === 1'b1) n_fd++;
      n_checks++;
      if (o.data !== e.data || o.fd !== e.fd || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL b2b_out: got %h fd=%b cyc=%0d, expected %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
      end
    end
    n_checks++; if (n_fd !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses, expected 2", n_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reset_mid_frame();
    test_gapped();
    test_unsigned_max();
    test_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
